// File: rtl/pattern_search_engine.sv
// -----------------------------------------------------------------------------
// pattern_search_engine
//
// Purpose:
//    Start/done-driven bus master that sits beside a byte-wide data memory.
//    On an accepted start it reads a 5-bit pattern (bits [7:3] of the byte at
//    PAT_ADDR), scans NBYTES message bytes starting at MSG_ADDR and counts:
//       ctb - in-byte 5-bit windows equal to the pattern (4 windows per byte)
//       cto - bytes that contain at least one in-byte match
//       cts - matches over the whole message bit string, including windows
//             that straddle two neighbouring bytes (byte 0 is the MSB end)
//    The three counts are written to RES_ADDR, RES_ADDR+1 and RES_ADDR+2,
//    after which done is raised and held until the next accepted start.
//
// Ports:
//    clock        in   1   system clock, rising edge
//    reset_n      in   1   asynchronous active-low reset
//    start        in   1   request, sampled on a rising edge (ignored while busy)
//    done         out  1   results written; held until the next accepted start
//    busy         out  1   operation in progress (LOAD_PAT, SCAN, WR_*)
//    mem_addr     out  AW  memory address
//    mem_rd_data  in   8   memory read data, valid in the same cycle as mem_addr
//    mem_wr_en    out  1   memory write strobe, one cycle per result
//    mem_wr_data  out  8   memory write data
// -----------------------------------------------------------------------------
module pattern_search_engine #(
   parameter int NBYTES   = 32,
   parameter int MSG_ADDR = 0,
   parameter int PAT_ADDR = 32,
   parameter int RES_ADDR = 33,
   parameter int AW       = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   output logic          done,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data
);

   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [AW-1:0] LP_MSG_ADDR = AW'(MSG_ADDR);
   localparam logic [AW-1:0] LP_PAT_ADDR = AW'(PAT_ADDR);
   localparam logic [AW-1:0] LP_RES_CTB  = AW'(RES_ADDR);
   localparam logic [AW-1:0] LP_RES_CTO  = AW'(RES_ADDR + 1);
   localparam logic [AW-1:0] LP_RES_CTS  = AW'(RES_ADDR + 2);
   localparam logic [KW-1:0] LP_K_LAST   = KW'(NBYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_PAT = 3'd1,
      ST_SCAN     = 3'd2,
      ST_WR_CTB   = 3'd3,
      ST_WR_CTO   = 3'd4,
      ST_WR_CTS   = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [4:0]      r_pat;
   logic [3:0]      r_prev_lo;    // only the low nibble of the previous byte feeds crossing windows
   logic [7:0]      r_ctb;
   logic [7:0]      r_cto;
   logic [7:0]      r_cts;
   logic            r_done;
   logic            r_busy;
   logic [AW-1:0]   r_mem_addr;
   logic            r_mem_wr_en;
   logic [7:0]      r_mem_wr_data;

   logic [11:0]     w_win;
   logic [3:0]      w_ctb_inc;
   logic [3:0]      w_cross_inc;
   logic [3:0]      w_cts_inc;
   logic            w_cto_inc;
   logic [7:0]      w_ctb_next;
   logic [7:0]      w_cto_next;
   logic [7:0]      w_cts_next;

   // Per-byte match counts for the byte currently on the read bus.
   always_comb begin
      w_win       = {r_prev_lo, mem_rd_data};
      w_ctb_inc   = 4'd0;
      w_cross_inc = 4'd0;
      for (int i = 0; i < 4; i++) begin
         w_ctb_inc = w_ctb_inc + {3'd0, (mem_rd_data[i +: 5] == r_pat)};
      end
      // Windows 0..3 of w_win are the in-byte ones, 4..7 straddle the boundary.
      for (int j = 0; j < 8; j++) begin
         w_cross_inc = w_cross_inc + {3'd0, (w_win[j +: 5] == r_pat)};
      end
      // The first byte has no predecessor, so only its in-byte windows exist.
      w_cts_inc  = (r_k == {KW{1'b0}}) ? w_ctb_inc : w_cross_inc;
      w_cto_inc  = (w_ctb_inc != 4'd0);
      w_ctb_next = r_ctb + {4'd0, w_ctb_inc};
      w_cto_next = r_cto + {7'd0, w_cto_inc};
      w_cts_next = r_cts + {4'd0, w_cts_inc};
   end

   // Control FSM, counters and all registered bus outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_k           <= {KW{1'b0}};
         r_pat         <= 5'd0;
         r_prev_lo     <= 4'd0;
         r_ctb         <= 8'd0;
         r_cto         <= 8'd0;
         r_cts         <= 8'd0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
         r_mem_addr    <= {AW{1'b0}};
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_data <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state     <= ST_LOAD_PAT;
                  r_done      <= 1'b0;
                  r_busy      <= 1'b1;
                  r_mem_addr  <= LP_PAT_ADDR;
                  r_mem_wr_en <= 1'b0;
               end else begin
                  r_state     <= r_state;
                  r_mem_wr_en <= 1'b0;
               end
            end
            ST_LOAD_PAT: begin
               r_pat      <= mem_rd_data[7:3];
               r_k        <= {KW{1'b0}};
               r_prev_lo  <= 4'd0;
               r_ctb      <= 8'd0;
               r_cto      <= 8'd0;
               r_cts      <= 8'd0;
               r_mem_addr <= LP_MSG_ADDR;
               r_state    <= ST_SCAN;
            end
            ST_SCAN: begin
               r_ctb     <= w_ctb_next;
               r_cto     <= w_cto_next;
               r_cts     <= w_cts_next;
               r_prev_lo <= mem_rd_data[3:0];
               if (r_k == LP_K_LAST) begin
                  // Last byte: present the final ctb so the first write needs no extra cycle.
                  r_state       <= ST_WR_CTB;
                  r_mem_addr    <= LP_RES_CTB;
                  r_mem_wr_en   <= 1'b1;
                  r_mem_wr_data <= w_ctb_next;
               end else begin
                  r_k        <= r_k + KW'(1);
                  r_mem_addr <= r_mem_addr + AW'(1);
               end
            end
            ST_WR_CTB: begin
               r_state       <= ST_WR_CTO;
               r_mem_addr    <= LP_RES_CTO;
               r_mem_wr_data <= r_cto;
            end
            ST_WR_CTO: begin
               r_state       <= ST_WR_CTS;
               r_mem_addr    <= LP_RES_CTS;
               r_mem_wr_data <= r_cts;
            end
            ST_WR_CTS: begin
               r_state     <= ST_DONE;
               r_mem_wr_en <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_wr_en <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign done        = r_done;
   assign busy        = r_busy;
   assign mem_addr    = r_mem_addr;
   assign mem_wr_en   = r_mem_wr_en;
   assign mem_wr_data = r_mem_wr_data;

endmodule
